// File: rtl/fetch_queue.sv
// Show-ahead instruction buffer between fetch and decode, holding {pc, instruction} pairs.
// The head entry is read combinationally; a NOP is presented while the buffer is empty.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [31:0]              in_ir,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [31:0]              out_ir,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP_IR = 32'h0000_0013;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PC_W+31:0]  mem [DEPTH];
  logic [PC_W+31:0]  head;
  logic              push;
  logic              pop;

  // Full/empty derive from the registered count only, so a pop never frees a slot in the same cycle.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);

  always_comb begin
    push = in_valid & in_ready & ~flush;
    pop  = out_valid & out_ready & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_pc, in_ir};
  end

  always_comb begin
    head   = mem[rd_ptr];
    out_ir = out_valid ? head[31:0] : NOP_IR;
    out_pc = out_valid ? head[PC_W+31:32] : '0;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a scoreboard queue records accepted entries and a
// negedge monitor pops and compares them as the queue hands entries to decode.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [31:0]       in_ir;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [31:0]       out_ir;
  logic [2:0]        count;

  int unsigned tests;
  int unsigned fails;
  logic [63:0] exp_q[$];

  fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ir(in_ir),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ir(out_ir),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mirrors occupancy, pops on each handshake and compares the head entry.
  always @(negedge clk) begin
    logic do_push;
    logic do_pop;
    if (!rst_n) begin
      exp_q.delete();
      chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_count", {61'b0, count}, 64'd0);
      chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
      chk("rst_out_ir", {32'b0, out_ir}, 64'h13);
    end else begin
      chk("count", {61'b0, count}, 64'(exp_q.size()));
      chk("out_valid", {63'b0, out_valid}, {63'b0, exp_q.size() != 0});
      chk("in_ready", {63'b0, in_ready}, {63'b0, exp_q.size() < DEPTH});
      if (exp_q.size() == 0) begin
        chk("empty_ir", {32'b0, out_ir}, 64'h13);
        chk("empty_pc", {32'b0, out_pc}, 64'd0);
      end
      do_pop  = out_ready && !flush && exp_q.size() != 0;
      do_push = in_valid && !flush && exp_q.size() < DEPTH;
      if (do_pop) begin
        chk("pop_pc", {32'b0, out_pc}, {32'b0, exp_q[0][63:32]});
        chk("pop_ir", {32'b0, out_ir}, {32'b0, exp_q[0][31:0]});
        void'(exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      else if (do_push) exp_q.push_back({in_pc, in_ir});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_ir     = ir;
    out_ready = rdy;
    flush     = fl;
    cyc();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_pc = '0;
    in_ir = '0;
    out_ready = 1'b0;

    // 1: pushes while held in reset are ignored
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h100, 32'hdead_beef, 1'b1, 1'b0);
    chk("t1_count", {61'b0, count}, 64'd0);
    chk("t1_out_ir", {32'b0, out_ir}, 64'h13);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    cyc();

    // 2: fill to full, attempt an extra push, then drain in order
    for (int i = 0; i < 4; i++)
      drive(1'b1, 32'(4 * i), 32'h0050_0093 + 32'(i) * 32'h0010_0000, 1'b0, 1'b0);
    chk("t2_count_full", {61'b0, count}, 64'd4);
    chk("t2_in_ready_full", {63'b0, in_ready}, 64'd0);
    chk("t2_head_pc", {32'b0, out_pc}, 64'h0);
    drive(1'b1, 32'h99, 32'h1111_1111, 1'b0, 1'b0);
    chk("t2_count_refused", {61'b0, count}, 64'd4);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t2_drained_valid", {63'b0, out_valid}, 64'd0);
    chk("t2_drained_ir", {32'b0, out_ir}, 64'h13);

    // 3: interleaved push/pop across the pointer wrap
    for (int k = 0; k < 6; k++)
      drive(1'b1, 32'h40 + 32'(4 * k), 32'h0000_1000 + 32'(k), k >= 1, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t3_count_end", {61'b0, count}, 64'd0);

    // 4: simultaneous push and pop at count 2
    drive(1'b1, 32'h10, 32'h0000_2010, 1'b0, 1'b0);
    drive(1'b1, 32'h14, 32'h0000_2014, 1'b0, 1'b0);
    drive(1'b1, 32'h20, 32'h0000_2020, 1'b1, 1'b0);
    chk("t4_count", {61'b0, count}, 64'd2);
    chk("t4_head_pc", {32'b0, out_pc}, 64'h14);
    for (int k = 0; k < 2; k++) drive(1'b0, '0, '0, 1'b1, 1'b0);

    // 5: full with pop and push offered: pop taken, push refused
    for (int i = 0; i < 4; i++)
      drive(1'b1, 32'h30 + 32'(4 * i), 32'h0000_3000 + 32'(i), 1'b0, 1'b0);
    drive(1'b1, 32'h50, 32'h0000_5050, 1'b1, 1'b0);
    chk("t5_count", {61'b0, count}, 64'd3);
    chk("t5_in_ready", {63'b0, in_ready}, 64'd1);
    chk("t5_head_pc", {32'b0, out_pc}, 64'h34);

    // 6: flush wins over concurrent push and pop
    drive(1'b1, 32'h60, 32'h0000_6060, 1'b1, 1'b1);
    chk("t6_count", {61'b0, count}, 64'd0);
    chk("t6_out_ir", {32'b0, out_ir}, 64'h13);
    chk("t6_out_pc", {32'b0, out_pc}, 64'h0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t6_count_after", {61'b0, count}, 64'd0);
    chk("t6_valid_after", {63'b0, out_valid}, 64'd0);

    // 7: asynchronous reset mid-operation discards contents
    drive(1'b1, 32'h70, 32'h0000_7070, 1'b0, 1'b0);
    drive(1'b1, 32'h74, 32'h0000_7074, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t7_count", {61'b0, count}, 64'd0);
    chk("t7_out_valid", {63'b0, out_valid}, 64'd0);
    chk("t7_out_ir", {32'b0, out_ir}, 64'h13);
    cyc();
    #2 rst_n = 1'b1;
    cyc();
    chk("t7_count_after", {61'b0, count}, 64'd0);
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
